// File: rtl/seg_dec_scan_if.sv
// Display bus between the sequence generator / board and the decimal-hex display back-end.
interface seg_dec_scan_if;
  logic [6:0] f;
  logic       hex_mode;
  logic [2:0] an;
  logic [3:0] seg_d;
  logic       busy;

  modport master (
    output f,
    output hex_mode,
    input  an,
    input  seg_d,
    input  busy
  );

  modport slave (
    input  f,
    input  hex_mode,
    output an,
    output seg_d,
    output busy
  );
endinterface

// File: rtl/seg_dec_scan.sv
// Converts a 7-bit value to three decimal (double-dabble) or hex digits, commits them
// atomically and time-multiplexes them onto the 3-bit select / 4-bit data display bus.
module seg_dec_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic          clk,
  input  logic          rst,
  seg_dec_scan_if.slave bus
);

  localparam int unsigned VAL_W  = 7;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned NDIG   = 3;
  localparam int unsigned SR_W   = NDIG * DIG_W + VAL_W;
  localparam int unsigned IT_W   = 3;
  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned LAST_IT = VAL_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [VAL_W-1:0]    f_q;
  logic                m_q;
  logic [VAL_W:0]      shown;
  logic [VAL_W:0]      cap;
  logic [SR_W-1:0]     sr;
  logic [IT_W-1:0]     it;
  logic [DIG_W-1:0]    dig [NDIG];
  logic [DIV_W-1:0]    div;
  logic [1:0]          an_q;
  logic                busy_q;
  logic                start_c;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (t[VAL_W + DIG_W*i +: DIG_W] >= DIG_W'(5))
        t[VAL_W + DIG_W*i +: DIG_W] = t[VAL_W + DIG_W*i +: DIG_W] + DIG_W'(3);
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  assign start_c = ({m_q, f_q} != shown);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start_c) state_n = CONV;
      CONV: if (it == IT_W'(LAST_IT)) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Input capture, conversion datapath and atomic digit commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= '0;
      m_q    <= 1'b0;
      shown  <= '0;
      cap    <= '0;
      sr     <= '0;
      it     <= '0;
      dig[0] <= '0;
      dig[1] <= '0;
      dig[2] <= '0;
      busy_q <= 1'b0;
    end else begin
      f_q    <= bus.f;
      m_q    <= bus.hex_mode;
      busy_q <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (start_c) begin
            cap <= {m_q, f_q};
            sr  <= {(SR_W-VAL_W)'(0), f_q};
            it  <= '0;
          end
        end
        CONV: begin
          sr <= dd_step(sr);
          it <= it + IT_W'(1);
        end
        DONE: begin
          if (cap[VAL_W]) begin
            dig[0] <= cap[3:0];
            dig[1] <= {1'b0, cap[6:4]};
            dig[2] <= '0;
          end else begin
            dig[0] <= sr[VAL_W +: DIG_W];
            dig[1] <= sr[VAL_W + DIG_W +: DIG_W];
            dig[2] <= sr[VAL_W + 2*DIG_W +: DIG_W];
          end
          shown <= cap;
        end
        default: ;
      endcase
    end
  end

  // Free-running digit scanner, independent of the conversion FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      an_q <= '0;
    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
      div  <= '0;
      an_q <= (an_q == 2'd2) ? 2'd0 : an_q + 2'd1;
    end else begin
      div  <= div + DIV_W'(1);
    end
  end

  assign bus.an   = {1'b0, an_q};
  assign bus.busy = busy_q;

  always_comb begin
    bus.seg_d = '0;
    case (an_q)
      2'd0:    bus.seg_d = dig[0];
      2'd1:    bus.seg_d = dig[1];
      2'd2:    bus.seg_d = dig[2];
      default: bus.seg_d = '0;
    endcase
  end

endmodule

// File: tb/tb_seg_dec_scan.sv
// Scoreboard bench for seg_dec_scan: stimulus pushes expected digit triples, a negedge
// monitor pops them on each commit and checks seg_d/an every cycle against a reference.
module tb_seg_dec_scan;

  localparam int unsigned SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_dec_scan_if bus ();

  seg_dec_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_failed = 0;

  logic [11:0] exp_q [$];
  logic [11:0] cur_exp = '0;
  logic [7:0]  last_req = '0;
  int          commits = 0;
  int          commit_n = 0;
  int          n = 0;
  int          blen = 0;
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_failed++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference digits {d2,d1,d0} computed from the value with plain arithmetic.
  function automatic logic [11:0] ref_digits(input int v, input bit m);
    if (m) return {4'd0, 4'(v / 16), 4'(v % 16)};
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // Monitor: commit detection, scoreboard pop, per-cycle scan checks.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_exp   = '0;
      blen      = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.busy) blen++;
      if (prev_busy && !bus.busy) begin
        check("busy_len", blen, 8);
        blen = 0;
        commits++;
        commit_n = n;
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 1, 0);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      check("an_cadence", int'(bus.an), (n / SCAN_DIV) % 3);
      if (bus.an < 3)
        check("seg_d", int'(bus.seg_d), int'(cur_exp[bus.an*4 +: 4]));
      prev_busy = bus.busy;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while ((bus.busy || exp_q.size() != 0) && k < 60) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= 60) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic convert(input int v, input bit m);
    int c0, n0, k;
    wait_idle();
    @(posedge clk); #2;
    bus.f        = 7'(v);
    bus.hex_mode = m;
    if ({m, 7'(v)} != last_req) begin
      exp_q.push_back(ref_digits(v, m));
      last_req = {m, 7'(v)};
      n0 = n;
      c0 = commits;
      k  = 0;
      while (commits == c0 && k < 30) begin
        @(posedge clk); #2;
        k++;
      end
      if (commits == c0) check("commit_timeout", 0, 1);
      else               check("latency", commit_n - (n0 + 1), 9);
    end
    repeat (3 * SCAN_DIV) @(posedge clk);
  endtask

  initial begin
    int busy_seen, c0, k;
    bus.f        = '0;
    bus.hex_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", int'(bus.an), 0);
    check("rst_seg_d", int'(bus.seg_d), 0);
    check("rst_busy", int'(bus.busy), 0);
    #1 rst = 1'b0;

    busy_seen = 0;
    repeat (50) begin
      @(posedge clk); #2;
      if (bus.busy) busy_seen++;
    end
    check("idle_after_reset", busy_seen, 0);

    convert(89, 1'b0);
    convert(127, 1'b0);
    convert(100, 1'b0);
    convert(89, 1'b1);
    convert(89, 1'b0);

    // Value change while a conversion is in flight: both commit, in order.
    wait_idle();
    @(posedge clk); #2;
    bus.f = 7'd5;
    exp_q.push_back(ref_digits(5, 1'b0));
    c0 = commits;
    repeat (3) @(posedge clk);
    #2;
    bus.f = 7'd64;
    exp_q.push_back(ref_digits(64, 1'b0));
    last_req = {1'b0, 7'd64};
    k = 0;
    while (commits < c0 + 2 && k < 50) begin
      @(posedge clk); #2;
      k++;
    end
    check("two_commits", commits - c0, 2);
    repeat (3 * SCAN_DIV) @(posedge clk);

    for (int i = 0; i < 20; i++)
      convert(int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)));

    // Asynchronous reset mid-cycle with nonzero digits shown.
    convert(77, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_an", int'(bus.an), 0);
    check("async_rst_seg_d", int'(bus.seg_d), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #2;
    bus.f = 7'd0;
    bus.hex_mode = 1'b0;
    last_req = '0;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Reset during the 4th CONV cycle, then full reconversion of the held value.
    @(posedge clk); #2;
    bus.f = 7'd120;
    exp_q.push_back(ref_digits(120, 1'b0));
    repeat (5) @(posedge clk);
    #2;
    check("midconv_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("midconv_rst_busy", int'(bus.busy), 0);
    check("midconv_rst_seg_d", int'(bus.seg_d), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.push_back(ref_digits(120, 1'b0));
    last_req = {1'b0, 7'd120};
    c0 = commits;
    k = 0;
    while (commits == c0 && k < 30) begin
      @(posedge clk); #2;
      k++;
    end
    if (commits == c0) check("midconv_commit_timeout", 0, 1);
    else               check("midconv_latency", commit_n - 1, 9);
    repeat (3 * SCAN_DIV) @(posedge clk);

    wait_idle();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
